// File: rtl/pr_skid_stage_pkg.sv
// Shared definitions for the parametrised pipeline-stage registers.
// Field widths and control-bit layout keep ID/EX, EX/MEM and MEM/WB wrappers packing alike.
package pr_pkg;

  typedef enum logic [1:0] {
    PR_EMPTY = 2'd0,
    PR_FULL  = 2'd1,
    PR_SKID  = 2'd2
  } pr_state_e;

  localparam int PR_PAYLOAD_W  = 96;
  localparam int PR_CTRL_W     = 24;
  localparam int PR_KILL_CNT_W = 16;

  // Control vector layout, LSB first; bubbles zero every one of these.
  localparam int PR_CTRL_REG_WE  = 0;
  localparam int PR_CTRL_MEM_RD  = 1;
  localparam int PR_CTRL_MEM_WR  = 2;
  localparam int PR_CTRL_BR_LSB  = 3;
  localparam int PR_CTRL_BR_W    = 5;
  localparam int PR_CTRL_ALU_LSB = 8;
  localparam int PR_CTRL_ALU_W   = 6;
  localparam int PR_CTRL_AUX_LSB = 14;
  localparam int PR_CTRL_AUX_W   = 10;

  function automatic logic [1:0] pr_occupancy(input pr_state_e st);
    case (st)
      PR_FULL: return 2'd1;
      PR_SKID: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pr_skid_stage.sv
// Pipeline-stage register: payload + control under valid/ready, optional skid entry,
// synchronous flush to bubbles with a saturating kill counter; 1-cycle latency when empty.
module pr_skid_stage
  import pr_pkg::*;
#(
  parameter int PAYLOAD_W  = PR_PAYLOAD_W,
  parameter int CTRL_W     = PR_CTRL_W,
  parameter int SKID_EN    = 1,
  parameter int KILL_CNT_W = PR_KILL_CNT_W
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FLUSH,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [PAYLOAD_W-1:0]  IN_PAYLOAD,
  input  logic [CTRL_W-1:0]     IN_CTRL,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [PAYLOAD_W-1:0]  OUT_PAYLOAD,
  output logic [CTRL_W-1:0]     OUT_CTRL,
  output logic [1:0]            OCCUPANCY,
  output logic [KILL_CNT_W-1:0] KILL_COUNT
);

  pr_state_e             state_q, state_d;
  logic                  main_vld_q, main_vld_d;
  logic                  in_rdy_q, in_rdy_d;
  logic [PAYLOAD_W-1:0]  main_pay_q, main_pay_d, skid_pay_q, skid_pay_d;
  logic [CTRL_W-1:0]     main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [KILL_CNT_W-1:0] kill_q, kill_d;
  logic [KILL_CNT_W:0]   kill_sum;
  logic [1:0]            kill_inc;
  logic                  in_xfer, out_xfer;

  assign in_xfer  = IN_VALID & IN_READY;
  assign out_xfer = main_vld_q & OUT_READY;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= PR_EMPTY;
      main_vld_q  <= 1'b0;
      in_rdy_q    <= 1'b1;
      main_pay_q  <= '0;
      main_ctrl_q <= '0;
      skid_pay_q  <= '0;
      skid_ctrl_q <= '0;
      kill_q      <= '0;
    end else begin
      state_q     <= state_d;
      main_vld_q  <= main_vld_d;
      in_rdy_q    <= in_rdy_d;
      main_pay_q  <= main_pay_d;
      main_ctrl_q <= main_ctrl_d;
      skid_pay_q  <= skid_pay_d;
      skid_ctrl_q <= skid_ctrl_d;
      kill_q      <= kill_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_pay_d  = main_pay_q;
    main_ctrl_d = main_ctrl_q;
    skid_pay_d  = skid_pay_q;
    skid_ctrl_d = skid_ctrl_q;
    kill_inc    = pr_occupancy(state_q) - {1'b0, out_xfer};
    kill_sum    = {1'b0, kill_q} + (KILL_CNT_W+1)'(kill_inc);
    kill_d      = kill_q;
    if (FLUSH) begin
      // Payload is left alone; only control must read as a bubble.
      state_d     = PR_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      kill_d      = kill_sum[KILL_CNT_W] ? '1 : kill_sum[KILL_CNT_W-1:0];
    end else begin
      case (state_q)
        PR_EMPTY: begin
          if (in_xfer) begin
            state_d     = PR_FULL;
            main_pay_d  = IN_PAYLOAD;
            main_ctrl_d = IN_CTRL;
          end
        end
        PR_FULL: begin
          if (in_xfer && out_xfer) begin
            main_pay_d  = IN_PAYLOAD;
            main_ctrl_d = IN_CTRL;
          end else if (out_xfer) begin
            state_d     = PR_EMPTY;
            main_ctrl_d = '0;
          end else if (in_xfer && SKID_EN != 0) begin
            state_d     = PR_SKID;
            skid_pay_d  = IN_PAYLOAD;
            skid_ctrl_d = IN_CTRL;
          end
        end
        PR_SKID: begin
          if (out_xfer) begin
            state_d     = PR_FULL;
            main_pay_d  = skid_pay_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = PR_EMPTY;
      endcase
    end
    main_vld_d = (state_d != PR_EMPTY);
    in_rdy_d   = (state_d != PR_SKID);
  end

  always_comb begin
    IN_READY    = (SKID_EN != 0) ? in_rdy_q : (!main_vld_q | OUT_READY);
    OUT_VALID   = main_vld_q;
    OUT_PAYLOAD = main_pay_q;
    OUT_CTRL    = main_ctrl_q;
    OCCUPANCY   = pr_occupancy(state_q);
    KILL_COUNT  = kill_q;
  end

endmodule

// File: tb/tb_pr_skid_stage.sv
// Three stage instances (skid, no-skid, 2-bit kill counter) driven one at a time
// against a queue-based reference model of the stage.
module tb_pr_skid_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int          sel;
  logic        rst, flush, in_vld, out_rdy;
  logic [95:0] in_pay;
  logic [23:0] in_ctrl;

  logic [2:0]  rst_v, in_rdy_v, out_vld_v;
  logic [95:0] out_pay_v [3];
  logic [23:0] out_ctrl_v [3];
  logic [1:0]  occ_v [3];
  logic [15:0] kill0, kill1;
  logic [1:0]  kill2;

  logic        in_rdy, out_vld;
  logic [95:0] out_pay;
  logic [23:0] out_ctrl;
  logic [1:0]  occ;
  logic [15:0] kill;

  int n_total = 0;
  int n_bad   = 0;

  always_comb begin
    for (int i = 0; i < 3; i++) rst_v[i] = rst | (sel != i);
  end

  pr_skid_stage #(.PAYLOAD_W(96), .CTRL_W(24), .SKID_EN(1), .KILL_CNT_W(16)) u_skid (
    .CLK(clk), .RESET(rst_v[0]), .FLUSH(flush), .IN_VALID(in_vld), .IN_READY(in_rdy_v[0]),
    .IN_PAYLOAD(in_pay), .IN_CTRL(in_ctrl), .OUT_VALID(out_vld_v[0]), .OUT_READY(out_rdy),
    .OUT_PAYLOAD(out_pay_v[0]), .OUT_CTRL(out_ctrl_v[0]), .OCCUPANCY(occ_v[0]), .KILL_COUNT(kill0));

  pr_skid_stage #(.PAYLOAD_W(96), .CTRL_W(24), .SKID_EN(0), .KILL_CNT_W(16)) u_noskid (
    .CLK(clk), .RESET(rst_v[1]), .FLUSH(flush), .IN_VALID(in_vld), .IN_READY(in_rdy_v[1]),
    .IN_PAYLOAD(in_pay), .IN_CTRL(in_ctrl), .OUT_VALID(out_vld_v[1]), .OUT_READY(out_rdy),
    .OUT_PAYLOAD(out_pay_v[1]), .OUT_CTRL(out_ctrl_v[1]), .OCCUPANCY(occ_v[1]), .KILL_COUNT(kill1));

  pr_skid_stage #(.PAYLOAD_W(96), .CTRL_W(24), .SKID_EN(1), .KILL_CNT_W(2)) u_sat (
    .CLK(clk), .RESET(rst_v[2]), .FLUSH(flush), .IN_VALID(in_vld), .IN_READY(in_rdy_v[2]),
    .IN_PAYLOAD(in_pay), .IN_CTRL(in_ctrl), .OUT_VALID(out_vld_v[2]), .OUT_READY(out_rdy),
    .OUT_PAYLOAD(out_pay_v[2]), .OUT_CTRL(out_ctrl_v[2]), .OCCUPANCY(occ_v[2]), .KILL_COUNT(kill2));

  always_comb begin
    in_rdy   = in_rdy_v[sel];
    out_vld  = out_vld_v[sel];
    out_pay  = out_pay_v[sel];
    out_ctrl = out_ctrl_v[sel];
    occ      = occ_v[sel];
    kill     = (sel == 2) ? {14'd0, kill2} : (sel == 1) ? kill1 : kill0;
  end

  // Reference model: ordered list of held entries plus a kill tally.
  typedef struct packed {
    logic [95:0] pay;
    logic [23:0] ctrl;
  } ent_t;

  ent_t        mq[$];
  int          mkill;
  logic [95:0] mlast;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s sel=%0d got=%0h exp=%0h t=%0t", tag, sel, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [95:0] p, input logic [23:0] c,
                       input logic ordy, input logic fl, input logic r);
    in_vld = v; in_pay = p; in_ctrl = c; out_rdy = ordy; flush = fl; rst = r;
  endtask

  task automatic cyc();
    bit   ix, ox, mrdy, was_rst, was_fl;
    int   kmax, nk;
    ent_t e;
    #1;
    kmax = (sel == 2) ? 3 : 65535;
    mrdy = (sel != 1) ? (mq.size() < 2) : (mq.size() == 0 || out_rdy);
    if (!rst) chk("in_rdy", {127'd0, in_rdy}, {127'd0, mrdy});
    ix = in_vld & mrdy;
    ox = (mq.size() > 0) & out_rdy;
    was_rst = rst;
    was_fl  = flush;
    @(posedge clk);
    #1;
    if (was_rst) begin
      mq.delete(); mkill = 0; mlast = '0;
    end else if (was_fl) begin
      nk = mkill + mq.size() - int'(ox);
      mkill = (nk > kmax) ? kmax : nk;
      mq.delete();
    end else begin
      if (ox) void'(mq.pop_front());
      if (ix) begin
        e.pay = in_pay; e.ctrl = in_ctrl;
        mq.push_back(e);
      end
      if (mq.size() > 0) mlast = mq[0].pay;
    end
    chk("out_vld", {127'd0, out_vld}, {127'd0, mq.size() > 0});
    chk("out_ctrl", {104'd0, out_ctrl}, (mq.size() > 0) ? {104'd0, mq[0].ctrl} : 128'd0);
    chk("occ", {126'd0, occ}, 128'(mq.size()));
    chk("kill", {112'd0, kill}, 128'(mkill));
    if (mq.size() > 0) chk("out_pay", {32'd0, out_pay}, {32'd0, mq[0].pay});
    else if (was_rst || was_fl) chk("pay_hold", {32'd0, out_pay}, {32'd0, mlast});
  endtask

  task automatic select(input int s);
    sel = s;
    drive(0, '0, '0, 0, 0, 1);
    cyc(); cyc();
    rst = 0;
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) begin
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom}, 24'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
      cyc();
    end
  endtask

  initial begin
    mkill = 0; mlast = '0;
    select(0);

    // First transfer after reset
    drive(1, 96'h40, 24'h000001, 1, 0, 0);
    cyc();
    chk("tp1_pay", {32'd0, out_pay}, 128'h40);
    chk("tp1_occ", {126'd0, occ}, 128'd1);
    drive(0, '0, '0, 1, 0, 0);
    cyc();

    // Fill main and skid, third entry blocked, then drain in order
    drive(1, 96'hA, 24'h00000A, 0, 0, 0); cyc();
    drive(1, 96'hB, 24'h00000B, 0, 0, 0); cyc();
    chk("tp2_occ", {126'd0, occ}, 128'd2);
    drive(1, 96'hC, 24'h00000C, 0, 0, 0); cyc();
    chk("tp2_rdy", {127'd0, in_rdy}, 128'd0);
    drive(1, 96'hC, 24'h00000C, 1, 0, 0); cyc();
    chk("tp2_b", {32'd0, out_pay}, 128'hB);
    cyc();
    chk("tp2_c", {32'd0, out_pay}, 128'hC);
    drive(0, '0, '0, 1, 0, 0); cyc(); cyc();

    // Reset while two entries are held with all control bits set
    drive(1, 96'h111, 24'hFFFFFF, 0, 0, 0); cyc();
    drive(1, 96'h222, 24'hFFFFFF, 0, 0, 0); cyc();
    drive(0, '0, '0, 0, 0, 1); cyc();
    chk("rst_ctrl", {104'd0, out_ctrl}, 128'd0);
    chk("rst_pay", {32'd0, out_pay}, 128'd0);
    chk("rst_kill", {112'd0, kill}, 128'd0);

    // Flush in skid state with a same-cycle input
    drive(1, 96'h31, 24'h000031, 0, 0, 0); cyc();
    drive(1, 96'h32, 24'h000032, 0, 0, 0); cyc();
    drive(1, 96'hDD, 24'h0000DD, 0, 1, 0); cyc();
    chk("fl_kill", {112'd0, kill}, 128'd2);
    chk("fl_pay", {32'd0, out_pay}, 128'h31);
    drive(0, '0, '0, 1, 0, 0); cyc(); cyc();
    rand_run(400);

    // Kill counter saturation
    select(2);
    for (int i = 0; i < 4; i++) begin
      drive(1, 96'(i + 5), 24'h000100, 0, 0, 0); cyc();
      drive(0, '0, '0, 0, 1, 0); cyc();
    end
    chk("sat_kill", {112'd0, kill}, 128'd3);
    drive(0, '0, '0, 0, 0, 0);
    rand_run(400);

    // No-skid instance streaming one entry per cycle
    select(1);
    for (int i = 0; i < 12; i++) begin
      drive(1, 96'(i + 100), 24'(i + 1), 1, 0, 0); cyc();
    end
    chk("ns_pay", {32'd0, out_pay}, 128'd111);
    rand_run(400);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
